// File: rtl/pipelined_array_multiplier_if.sv
// Handshake bundle for the pipelined array multiplier: operand issue side
// (in_valid/in_ready) and product delivery side (out_valid/out_ready).
interface pipelined_array_multiplier_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/pipelined_array_multiplier.sv
// N x N shift-and-add array multiplier split into K register stages of
// ROWS_PER_STAGE adder rows each. Signed operations use Baugh-Wooley
// correction so the same array serves both modes; the mode bit rides along
// with its operands. A single global stall freezes every stage under
// backpressure.
module pipelined_array_multiplier #(
  parameter int N              = 8,
  parameter int ROWS_PER_STAGE = 2
) (
  input logic clk,
  input logic rst,
  pipelined_array_multiplier_if.slave bus
);
  localparam int K  = (N - 1 + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
  localparam int PW = 2 * N;

  // Baugh-Wooley constant ones at bit N and bit 2N-1.
  localparam logic [PW-1:0] BW_CONST = (PW'(1) << N) | (PW'(1) << (PW - 1));

  // Partial-product row i, already shifted into product position. In signed
  // mode the sign-weighted terms are inverted: the row MSB for rows below
  // N-1, and every term except the MSB for the final row.
  function automatic logic [PW-1:0] row_term(input logic [N-1:0] a,
                                             input logic [N-1:0] b,
                                             input logic         sgn,
                                             input int           i);
    logic [N-1:0] row;
    row = a & {N{b[i]}};
    if (sgn) begin
      if (i == N - 1) row[N-2:0] = ~row[N-2:0];
      else            row[N-1]   = ~row[N-1];
    end
    return PW'(row) << i;
  endfunction

  logic          stall;
  logic [N-1:0]  a_p   [0:K-1];
  logic [N-1:0]  b_p   [0:K-1];
  logic          sgn_p [0:K-1];
  logic          vld_p [0:K];
  logic [PW-1:0] acc_p [1:K];
  logic [PW-1:0] sum_c [1:K];

  assign stall         = vld_p[K] && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = vld_p[K];
  assign bus.p         = acc_p[K];

  // Adder rows for each stage: stage 1 seeds with row 0 (plus the signed
  // constants), every stage then ripples in its own slice of rows 1..N-1.
  always_comb begin
    for (int k = 1; k <= K; k++) begin
      if (k == 1) sum_c[k] = row_term(a_p[0], b_p[0], sgn_p[0], 0) +
                             (sgn_p[0] ? BW_CONST : '0);
      else        sum_c[k] = acc_p[(k > 1) ? k - 1 : 1];
      for (int i = 1; i < N; i++) begin
        if (i > (k - 1) * ROWS_PER_STAGE && i <= k * ROWS_PER_STAGE)
          sum_c[k] = sum_c[k] + row_term(a_p[k-1], b_p[k-1], sgn_p[k-1], i);
      end
    end
  end

  // Stage valid flags: advance together unless stalled, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= K; k++) vld_p[k] <= 1'b0;
    end else if (!stall) begin
      vld_p[0] <= bus.in_valid;
      for (int k = 1; k <= K; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // --- stage 0: operand capture; stages 1..K: partial sums; stage K drives p
  always_ff @(posedge clk) begin
    if (!stall) begin
      a_p[0]   <= bus.a;
      b_p[0]   <= bus.b;
      sgn_p[0] <= bus.is_signed;
      for (int k = 1; k < K; k++) begin
        a_p[k]   <= a_p[k-1];
        b_p[k]   <= b_p[k-1];
        sgn_p[k] <= sgn_p[k-1];
        acc_p[k] <= sum_c[k];
      end
    end
    if (rst)         acc_p[K] <= '0;
    else if (!stall) acc_p[K] <= sum_c[K];
  end
endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Bench for pipelined_array_multiplier: directed checks on the default
// configuration plus a randomized sweep across several N / ROWS_PER_STAGE
// instances, all scored against a plain-arithmetic product model.
module tb_pipelined_array_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  bit   sweep_go = 1'b0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  // Exact product of two n-bit operands, reduced to 2n bits.
  function automatic logic [63:0] ref_mul(input int n, input logic [63:0] a,
                                          input logic [63:0] b, input logic s);
    longint      sa, sb;
    logic [63:0] mask;
    mask = (64'd1 << (2 * n)) - 64'd1;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[n-1]) sa = sa - (longint'(1) << n);
    if (s && b[n-1]) sb = sb - (longint'(1) << n);
    return 64'(sa * sb) & mask;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Default-configuration instance (N=8, ROWS_PER_STAGE=2, K=4).
  pipelined_array_multiplier_if #(.N(8)) dif ();
  pipelined_array_multiplier #(.N(8), .ROWS_PER_STAGE(2)) dut (
    .clk(clk), .rst(rst), .bus(dif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation: checks acceptance, latency and product.
  task automatic dir_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] exp);
    int lat;
    dif.in_valid = 1'b1; dif.a = a; dif.b = b; dif.is_signed = s; dif.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, dif.in_ready, 1);
    tick();
    dif.in_valid = 1'b0;
    lat = 1;
    while (!dif.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_p"}, dif.p, exp);
    tick();
  endtask

  // Randomized sweep instances: (N, R) = (4,1) (4,3) (8,1) (8,3) (8,7) (16,1) (16,3) (16,15).
  for (genvar c = 0; c < 8; c++) begin : g_sweep
    localparam int NN = (c < 2) ? 4 : (c < 5) ? 8 : 16;
    localparam int RR = (c == 0 || c == 2 || c == 5) ? 1 :
                        (c == 1 || c == 3 || c == 6) ? 3 : NN - 1;
    localparam int KK = (NN - 1 + RR - 1) / RR;

    pipelined_array_multiplier_if #(.N(NN)) sif ();
    pipelined_array_multiplier #(.N(NN), .ROWS_PER_STAGE(RR)) u_dut (
      .clk(clk), .rst(rst), .bus(sif)
    );

    logic [63:0] exp_q [$];
    int          cyc_q [$];
    int          stl_q [$];
    int          n_acc;
    int          stalls;
    bit          seen;

    initial begin : drv
      sif.in_valid = 1'b0; sif.out_ready = 1'b1;
      sif.a = '0; sif.b = '0; sif.is_signed = 1'b0;
      n_acc = 0; stalls = 0; seen = 1'b0;
      wait (sweep_go);
      tick();
      for (int cyc = 0; cyc < 20000 && (n_acc < 2000 || exp_q.size() != 0); cyc++) begin
        if (n_acc < 2000) begin
          sif.in_valid  = ($urandom_range(0, 99) < 80);
          sif.a         = NN'($urandom);
          sif.b         = NN'($urandom);
          sif.is_signed = n_acc[0];
        end else begin
          sif.in_valid = 1'b0;
        end
        sif.out_ready = (n_acc >= 2000) || ($urandom_range(0, 99) < 75);
        @(negedge clk);
        chk($sformatf("sweep%0d_in_ready", c), sif.in_ready,
            !(sif.out_valid && !sif.out_ready));
        if (sif.out_valid) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("sweep%0d_spurious_out_valid", c), sif.out_valid, 0);
          end else begin
            if (!seen) begin
              chk($sformatf("sweep%0d_latency", c), cyc - cyc_q[0],
                  KK + 1 + (stalls - stl_q[0]));
              seen = 1'b1;
            end
            if (sif.out_ready) begin
              chk($sformatf("sweep%0d_p", c), 64'(sif.p), exp_q[0]);
              void'(exp_q.pop_front());
              void'(cyc_q.pop_front());
              void'(stl_q.pop_front());
              seen = 1'b0;
            end
          end
        end
        if (sif.out_valid && !sif.out_ready) stalls++;
        if (sif.in_valid && sif.in_ready) begin
          exp_q.push_back(ref_mul(NN, 64'(sif.a), 64'(sif.b), sif.is_signed));
          cyc_q.push_back(cyc);
          stl_q.push_back(stalls);
          n_acc++;
        end
        tick();
      end
      chk($sformatf("sweep%0d_accepted", c), n_acc, 2000);
      chk($sformatf("sweep%0d_drained", c), exp_q.size(), 0);
      done_cnt++;
    end
  end

  initial begin : main
    logic [63:0] q [$];
    logic [15:0] prev_p;
    bit          prev_stall;
    int          sent, got, lat;

    // Reset with operations streaming in: nothing may survive it.
    rst = 1'b1;
    dif.in_valid = 1'b1; dif.out_ready = 1'b1; dif.is_signed = 1'b0;
    dif.a = 8'h12; dif.b = 8'h34;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_out_valid", dif.out_valid, 0);
      chk("rst_p", dif.p, 0);
      dif.a = 8'($urandom); dif.b = 8'($urandom);
    end
    rst = 1'b0;
    dif.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_out_valid", dif.out_valid, 0);
    end

    // Directed products (first one also measures post-reset latency).
    dir_op("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    dir_op("u_0d_0b", 8'h0D, 8'h0B, 1'b0, 16'h008F);
    dir_op("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
    dir_op("s_ff_05", 8'hFF, 8'h05, 1'b1, 16'hFFFB);
    dir_op("s_7f_81", 8'h7F, 8'h81, 1'b1, 16'hC0FF);
    dir_op("u_00_ff", 8'h00, 8'hFF, 1'b0, 16'h0000);

    // Back-to-back mixed mode on consecutive cycles.
    dif.out_ready = 1'b1; dif.in_valid = 1'b1;
    dif.a = 8'hFF; dif.b = 8'h02; dif.is_signed = 1'b0;
    tick();
    dif.is_signed = 1'b1;
    tick();
    dif.in_valid = 1'b0;
    lat = 2;
    while (!dif.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("mix_latency", lat, 5);
    chk("mix_unsigned_p", dif.p, 16'h01FE);
    tick();
    chk("mix_second_valid", dif.out_valid, 1);
    chk("mix_signed_p", dif.p, 16'hFFFE);
    tick();

    // Reset mid-operation: three in flight, then reset.
    dif.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dif.a = 8'($urandom); dif.b = 8'($urandom);
      tick();
    end
    dif.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("midrst_out_valid", dif.out_valid, 0);
      tick();
    end

    // Backpressure: 8 random ops, out_ready low for 3 cycles mid-stream.
    sent = 0; got = 0; prev_stall = 1'b0; prev_p = '0;
    for (int t = 0; t < 60 && got < 8; t++) begin
      dif.out_ready = !(t >= 6 && t < 9);
      dif.in_valid  = (sent < 8);
      dif.a = 8'($urandom); dif.b = 8'($urandom); dif.is_signed = 1'($urandom);
      @(negedge clk);
      chk("bp_in_ready", dif.in_ready, !(dif.out_valid && !dif.out_ready));
      if (t >= 6 && t < 9) chk("bp_stalled_in_ready", dif.in_ready, 0);
      if (prev_stall) begin
        chk("bp_hold_valid", dif.out_valid, 1);
        chk("bp_hold_p", dif.p, prev_p);
      end
      prev_stall = dif.out_valid && !dif.out_ready;
      prev_p     = dif.p;
      if (dif.in_valid && dif.in_ready) begin
        q.push_back(ref_mul(8, 64'(dif.a), 64'(dif.b), dif.is_signed));
        sent++;
      end
      if (dif.out_valid && dif.out_ready) begin
        if (q.size() == 0) begin
          chk("bp_spurious_out_valid", dif.out_valid, 0);
        end else begin
          chk("bp_p", 64'(dif.p), q.pop_front());
          got++;
        end
      end
      tick();
    end
    dif.in_valid = 1'b0;
    chk("bp_results", got, 8);

    // Parameter sweep runs on the other instances concurrently.
    sweep_go = 1'b1;
    for (int i = 0; i < 30000 && done_cnt < 8; i++) @(posedge clk);
    chk("sweep_complete", done_cnt, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
